alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_pkg.sv | 44 ++++
 rtl/alu_exec_unit_stack.sv | 67 ++++++
 rtl/alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execution unit: opcodes, operand/destination
// selects and the sequencing FSM states.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_MOV = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    SRC_RF   = 2'd0,
    SRC_BIT  = 2'd1,
    SRC_WORD = 2'd2,
    SRC_IMM  = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    DST_RF   = 2'd0,
    DST_BIT  = 2'd1,
    DST_WORD = 2'd2,
    DST_NONE = 2'd3
  } dst_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_exec_unit_stack.sv
// Return-address stack: push writes at the pointer, pop decrements; any
// overflow, underflow or push/pop conflict is ignored and latches err_o.
module alu_ret_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [PC_WIDTH-1:0] top_o,
  output logic                err_o
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic                full, empty;
  logic [IW-1:0]       wr_idx, rd_idx;
  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];

  assign full   = (ptr_q == PW'(STACK_DEPTH));
  assign empty  = (ptr_q == '0);
  assign wr_idx = ptr_q[IW-1:0];
  assign rd_idx = IW'(ptr_q - 1'b1);

  always_comb begin
    ptr_d = ptr_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (push_i && pop_i) begin
      err_d = 1'b1;
    end else if (push_i) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
        wr_en = 1'b1;
      end
    end else if (pop_i) begin
      if (empty) err_d = 1'b1;
      else       ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= pc_i;
  end

  assign top_o = empty ? '0 : mem_q[rd_idx];
  assign err_o = err_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: IDLE accepts, READ fetches operands from
// RF / word memory / bit memory, EXEC computes, WRITE commits and strobes.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int RF_SIZE     = 16,
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] src1,
  input  logic [ADDR_WIDTH-1:0] src2,
  input  logic [1:0]            src1_sel,
  input  logic [1:0]            src2_sel,
  input  logic [ADDR_WIDTH-1:0] dest,
  input  logic [1:0]            dest_sel,
  input  logic                  push,
  input  logic                  pop,
  input  logic [PC_WIDTH-1:0]   pc_in,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  flag_b,
  output logic [PC_WIDTH-1:0]   stack_top,
  output logic                  stack_err,
  output logic                  op_err
);

  localparam int RF_IW = $clog2(RF_SIZE);
  localparam int MEM_N = 2 ** ADDR_WIDTH;

  state_e state_q, state_d;
  logic   rdy_q;
  logic   accept;
  logic   wr_rf, wr_word, wr_bit, stk_push, stk_pop;

  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] src1_q, src2_q, dest_q;
  logic [1:0]            s1sel_q, s2sel_q, dsel_q;
  logic                  push_q, pop_q;
  logic [PC_WIDTH-1:0]   pc_q;

  logic [WIDTH-1:0] rf_q   [RF_SIZE];
  logic [WIDTH-1:0] wmem_q [MEM_N];
  logic             bmem_q [MEM_N];

  logic [WIDTH-1:0] rf_a_q, rf_b_q, word_a_q, word_b_q;
  logic             bit_a_q, bit_b_q;
  logic [WIDTH-1:0] opa, opb;

  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_c_q, flag_z_q, flag_b_q;
  logic             c_d, z_d, b_d;
  logic             legal;
  logic [WIDTH:0]   sum;
  logic             res_valid_q, op_err_q;

  logic [RF_IW-1:0] rf_ia, rf_ib, rf_id;
  logic             rf_ok_a, rf_ok_b, rf_ok_d;

  assign in_ready = rdy_q && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_rf    = 1'b0;
    wr_word  = 1'b0;
    wr_bit   = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: begin
        state_d  = ST_IDLE;
        stk_push = push_q;
        stk_pop  = pop_q;
        if (op_is_legal(op_q)) begin
          wr_rf   = (dsel_q == DST_RF) && rf_ok_d;
          wr_word = (dsel_q == DST_WORD);
          wr_bit  = (dsel_q == DST_BIT);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_code;
      src1_q  <= src1;
      src2_q  <= src2;
      s1sel_q <= src1_sel;
      s2sel_q <= src2_sel;
      dest_q  <= dest;
      dsel_q  <= dest_sel;
      push_q  <= push;
      pop_q   <= pop;
      pc_q    <= pc_in;
    end
  end

  assign rf_ia = src1_q[RF_IW-1:0];
  assign rf_ib = src2_q[RF_IW-1:0];
  assign rf_id = dest_q[RF_IW-1:0];

  // Indices beyond the register file only exist when RF_SIZE is not a power of two.
  generate
    if (RF_SIZE == (1 << RF_IW)) begin : g_rf_pow2
      assign rf_ok_a = 1'b1;
      assign rf_ok_b = 1'b1;
      assign rf_ok_d = 1'b1;
    end else begin : g_rf_part
      assign rf_ok_a = (rf_ia < RF_IW'(RF_SIZE));
      assign rf_ok_b = (rf_ib < RF_IW'(RF_SIZE));
      assign rf_ok_d = (rf_id < RF_IW'(RF_SIZE));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (state_q == ST_READ) begin
      word_a_q <= wmem_q[src1_q];
      word_b_q <= wmem_q[src2_q];
      bit_a_q  <= bmem_q[src1_q];
      bit_b_q  <= bmem_q[src2_q];
      rf_a_q   <= rf_ok_a ? rf_q[rf_ia] : '0;
      rf_b_q   <= rf_ok_b ? rf_q[rf_ib] : '0;
    end
    if (wr_word) wmem_q[dest_q] <= res_q;
    if (wr_bit)  bmem_q[dest_q] <= res_q[0];
  end

  function automatic logic [WIDTH-1:0] pick(input logic [1:0]            sel,
                                            input logic [WIDTH-1:0]      rf_v,
                                            input logic [WIDTH-1:0]      word_v,
                                            input logic                  bit_v,
                                            input logic [ADDR_WIDTH-1:0] imm);
    case (sel)
      SRC_RF:   return rf_v;
      SRC_BIT:  return {{(WIDTH-1){1'b0}}, bit_v};
      SRC_WORD: return word_v;
      default:  return WIDTH'(imm);
    endcase
  endfunction

  assign opa = pick(s1sel_q, rf_a_q, word_a_q, bit_a_q, src1_q);
  assign opb = pick(s2sel_q, rf_b_q, word_b_q, bit_b_q, src2_q);

  always_comb begin
    sum   = '0;
    res_d = '0;
    c_d   = flag_c_q;
    z_d   = flag_z_q;
    b_d   = flag_b_q;
    legal = op_is_legal(op_q);
    case (op_q)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, (op_q == OP_ADC) & flag_c_q};
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
      end
      // Sign bit of the widened difference is exactly a < b + borrow_in.
      OP_SUB, OP_SBB: begin
        sum   = {1'b0, opa} - {1'b0, opb} - {{WIDTH{1'b0}}, (op_q == OP_SBB) & flag_b_q};
        res_d = sum[WIDTH-1:0];
        b_d   = sum[WIDTH];
      end
      OP_AND: res_d = opa & opb;
      OP_OR:  res_d = opa | opb;
      OP_XOR: res_d = opa ^ opb;
      OP_NOT: res_d = ~opa;
      OP_MOV: res_d = opa;
      OP_SHL: begin
        res_d = {opa[WIDTH-2:0], 1'b0};
        c_d   = opa[WIDTH-1];
      end
      OP_SHR: begin
        res_d = {1'b0, opa[WIDTH-1:1]};
        c_d   = opa[0];
      end
      default: res_d = '0;
    endcase
    if (legal) z_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_b_q    <= 1'b0;
      res_valid_q <= 1'b0;
      op_err_q    <= 1'b0;
      for (int i = 0; i < RF_SIZE; i++) rf_q[i] <= '0;
    end else begin
      res_valid_q <= (state_q == ST_EXEC);
      op_err_q    <= (state_q == ST_EXEC) && !legal;
      if (state_q == ST_EXEC) begin
        res_q    <= res_d;
        flag_c_q <= c_d;
        flag_z_q <= z_d;
        flag_b_q <= b_d;
      end
      if (wr_rf) rf_q[rf_id] <= res_q;
    end
  end

  alu_ret_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push_i(stk_push),
    .pop_i (stk_pop),
    .pc_i  (pc_q),
    .top_o (stack_top),
    .err_o (stack_err)
  );

  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_b    = flag_b_q;
  assign op_err    = op_err_q;

endmodule
